// File: rtl/vga_sync_out_pkg.sv
// rtl/vga_sync_out_pkg.sv - shared state encodings, default timings and helpers for the sync output stage
package vga_sync_out_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRONT = 2'd1;
    localparam logic [1:0] ST_SYNC  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;

    localparam int RGB_W = 3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Wide enough to hold the largest porch/width value itself.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int w;
        w = $clog2(max4(a, b, c, d) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vga_sync_out_sync_pulse_fsm.sv
// rtl/vga_sync_out_sync_pulse_fsm.sv - porch/width sync pulse generator driven by a blank window and a tick
module sync_pulse_fsm
    import vga_sync_out_pkg::*;
#(
    parameter int   PORCH = DEF_H_FRONT,
    parameter int   WIDTH = DEF_H_SYNC,
    parameter int   CNT_W = 7,
    parameter logic POL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic blank,
    input  logic rise,
    input  logic tick,
    input  logic abort,
    output logic sync,
    output logic err
);

    localparam logic [CNT_W-1:0] PORCH_C = CNT_W'(PORCH);
    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             kill;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    // Losing the blank window (or an external abort) mid-pulse is a timing fault.
    assign kill = ((state == ST_FRONT) || (state == ST_SYNC)) && (!blank || abort);
    assign err  = kill;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (kill) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        cnt_n   = '0;
                        state_n = (PORCH == 0) ? ST_SYNC : ST_FRONT;
                    end
                end
                ST_FRONT: begin
                    if (tick) begin
                        if (cnt_inc >= PORCH_C) begin
                            state_n = ST_SYNC;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ST_SYNC: begin
                    if (tick) begin
                        if (cnt_inc >= WIDTH_C) begin
                            state_n = ST_HOLD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!blank) state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sync  <= ~POL;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sync  <= (state_n == ST_SYNC) ? POL : ~POL;
        end
    end

endmodule

// File: rtl/vga_sync_out.sv
// rtl/vga_sync_out.sv - video output stage: HSync/VSync pulse placement and registered RGB bus
module vga_sync_out
    import vga_sync_out_pkg::*;
#(
    parameter int               H_FRONT  = DEF_H_FRONT,
    parameter int               H_SYNC   = DEF_H_SYNC,
    parameter int               V_FRONT  = DEF_V_FRONT,
    parameter int               V_SYNC   = DEF_V_SYNC,
    parameter logic             SYNC_POL = 1'b0,
    parameter logic [3*RGB_W-1:0] BALL_RGB = 9'h1FF
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_HBlank,
    input  logic             i_VBlank,
    input  logic             i_HReset,
    input  logic             i_VReset,
    input  logic             i_Ball,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic [RGB_W-1:0] o_Red,
    output logic [RGB_W-1:0] o_Green,
    output logic [RGB_W-1:0] o_Blue,
    output logic             o_SyncErr
);

    localparam int CNT_W = cnt_width(H_FRONT, H_SYNC, V_FRONT, V_SYNC);

    logic               hblank_q;
    logic               vblank_q;
    logic               h_rise;
    logic               v_rise;
    logic               h_err;
    logic               v_err;
    logic               err_q;
    logic [3*RGB_W-1:0] rgb_q;

    assign h_rise = i_HBlank & ~hblank_q;
    assign v_rise = i_VBlank & ~vblank_q;

    sync_pulse_fsm #(
        .PORCH (H_FRONT),
        .WIDTH (H_SYNC),
        .CNT_W (CNT_W),
        .POL   (SYNC_POL)
    ) u_h_fsm (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .blank (i_HBlank),
        .rise  (h_rise),
        .tick  (1'b1),
        .abort (1'b0),
        .sync  (o_HSync),
        .err   (h_err)
    );

    // Vertical timing counts lines, so it only advances on end-of-line pulses.
    sync_pulse_fsm #(
        .PORCH (V_FRONT),
        .WIDTH (V_SYNC),
        .CNT_W (CNT_W),
        .POL   (SYNC_POL)
    ) u_v_fsm (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .blank (i_VBlank),
        .rise  (v_rise),
        .tick  (i_HReset),
        .abort (i_VReset),
        .sync  (o_VSync),
        .err   (v_err)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            rgb_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            hblank_q <= i_HBlank;
            vblank_q <= i_VBlank;
            rgb_q    <= (i_Ball && !i_HBlank && !i_VBlank) ? BALL_RGB : '0;
            err_q    <= err_q | h_err | v_err;
        end
    end

    assign o_Red     = rgb_q[3*RGB_W-1:2*RGB_W];
    assign o_Green   = rgb_q[2*RGB_W-1:RGB_W];
    assign o_Blue    = rgb_q[RGB_W-1:0];
    assign o_SyncErr = err_q;

endmodule

// File: tb/tb_vga_sync_out.sv
// tb/tb_vga_sync_out.sv - scoreboard bench for vga_sync_out with directed per-cycle vectors
module tb_vga_sync_out;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [8:0] rgb;
        logic       err;
    } exp_t;

    localparam logic [8:0] W = 9'h1FF;
    localparam logic [8:0] Z = 9'h000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hblank, vblank, hreset, vreset, ball;
    logic       hsync, vsync, sync_err;
    logic [2:0] red, green, blue;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    vga_sync_out #(
        .H_FRONT  (2),
        .H_SYNC   (3),
        .V_FRONT  (1),
        .V_SYNC   (2),
        .SYNC_POL (1'b0),
        .BALL_RGB (9'h1FF)
    ) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_HBlank  (hblank),
        .i_VBlank  (vblank),
        .i_HReset  (hreset),
        .i_VReset  (vreset),
        .i_Ball    (ball),
        .o_HSync   (hsync),
        .o_VSync   (vsync),
        .o_Red     (red),
        .o_Green   (green),
        .o_Blue    (blue),
        .o_SyncErr (sync_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rst, input logic hb, input logic vb, input logic hr,
                        input logic vr, input logic bl, input logic ehs, input logic evs,
                        input logic [8:0] ergb, input logic eerr, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        if (!rst) begin
            hblank = 1'($urandom_range(0, 1));
            vblank = 1'($urandom_range(0, 1));
            hreset = 1'($urandom_range(0, 1));
            vreset = 1'($urandom_range(0, 1));
            ball   = 1'($urandom_range(0, 1));
        end else begin
            hblank = hb;
            vblank = vb;
            hreset = hr;
            vreset = vr;
            ball   = bl;
        end
        e.hs  = ehs;
        e.vs  = evs;
        e.rgb = ergb;
        e.err = eerr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n, input logic eerr, input string nm);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 1, 1, Z, eerr, nm);
    endtask

    // Monitor: compares each expected output well after the edge that produced it.
    initial begin
        exp_t  e;
        string nm;
        logic [8:0] got_rgb;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got_rgb = {red, green, blue};
                n_vec++;
                if (hsync !== e.hs || vsync !== e.vs || got_rgb !== e.rgb || sync_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s: hs/vs/rgb/err got %b/%b/%h/%b want %b/%b/%h/%b",
                             nm, hsync, vsync, got_rgb, sync_err, e.hs, e.vs, e.rgb, e.err);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        hblank = 1'b0; vblank = 1'b0; hreset = 1'b0; vreset = 1'b0; ball = 1'b0;

        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 1, Z, 0, "reset");
        idle(2, 0, "idle");

        // HSync placement: 10-cycle HBlank, sync low on the 3rd..5th outputs after the rise
        step(1, 1, 0, 0, 0, 0, 1, 1, Z, 0, "h_rise");
        step(1, 1, 0, 0, 0, 0, 1, 1, Z, 0, "h_front");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 1, Z, 0, "h_sync");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 1, 1, Z, 0, "h_hold");
        idle(2, 0, "h_release");

        // Colour and blanking
        step(1, 0, 0, 0, 0, 1, 1, 1, W, 0, "rgb_ball");
        step(1, 0, 0, 0, 0, 1, 1, 1, W, 0, "rgb_ball");
        step(1, 1, 0, 0, 0, 1, 1, 1, Z, 0, "rgb_hblank");
        step(1, 1, 0, 0, 0, 1, 1, 1, Z, 0, "rgb_hblank");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 1, 0, 1, Z, 0, "rgb_hblank_sync");
        step(1, 1, 0, 0, 0, 1, 1, 1, Z, 0, "rgb_hblank");
        step(1, 0, 0, 0, 0, 1, 1, 1, W, 0, "rgb_after");
        step(1, 0, 0, 0, 0, 0, 1, 1, Z, 0, "rgb_off");

        // VSync placement, ball held high to also check VBlank masks colour
        step(1, 0, 1, 0, 0, 1, 1, 1, Z, 0, "v_rise");
        step(1, 0, 1, 1, 0, 1, 1, 0, Z, 0, "v_pulse1");
        step(1, 0, 1, 0, 0, 1, 1, 0, Z, 0, "v_gap");
        step(1, 0, 1, 1, 0, 1, 1, 0, Z, 0, "v_pulse2");
        step(1, 0, 1, 0, 0, 1, 1, 0, Z, 0, "v_gap");
        step(1, 0, 1, 1, 0, 1, 1, 1, Z, 0, "v_pulse3");
        step(1, 0, 1, 0, 0, 1, 1, 1, Z, 0, "v_gap");
        step(1, 0, 1, 1, 0, 1, 1, 1, Z, 0, "v_pulse4");
        step(1, 0, 0, 0, 0, 1, 1, 1, W, 0, "v_release");
        idle(1, 0, "idle");

        // VBlank rise coincident with HReset: that pulse is not counted
        step(1, 0, 1, 1, 0, 0, 1, 1, Z, 0, "v_coinc");
        step(1, 0, 1, 0, 0, 0, 1, 1, Z, 0, "v_wait");
        step(1, 0, 1, 1, 0, 0, 1, 0, Z, 0, "v_first");
        step(1, 0, 1, 1, 0, 0, 1, 0, Z, 0, "v_second");
        step(1, 0, 1, 1, 0, 0, 1, 1, Z, 0, "v_end");
        step(1, 0, 0, 0, 0, 0, 1, 1, Z, 0, "v_release2");
        idle(1, 0, "idle");

        // Early HBlank fall: one sync cycle, sticky error
        step(1, 1, 0, 0, 0, 0, 1, 1, Z, 0, "h_early_rise");
        step(1, 1, 0, 0, 0, 0, 1, 1, Z, 0, "h_early_front");
        step(1, 1, 0, 0, 0, 0, 0, 1, Z, 0, "h_early_sync");
        step(1, 0, 0, 0, 0, 0, 1, 1, Z, 1, "h_abort");
        idle(3, 1, "err_sticky");

        // Reset mid-pulse forces syncs inactive and clears the error
        step(1, 1, 0, 0, 0, 0, 1, 1, Z, 1, "mid_rise");
        step(1, 1, 0, 0, 0, 0, 1, 1, Z, 1, "mid_front");
        step(1, 1, 0, 0, 0, 0, 0, 1, Z, 1, "mid_sync");
        step(0, 0, 0, 0, 0, 0, 1, 1, Z, 0, "mid_reset");
        step(0, 0, 0, 0, 0, 0, 1, 1, Z, 0, "mid_reset");
        idle(2, 0, "reset_clears");

        // VReset inside the V pulse aborts it; held VBlank must not retrigger
        step(1, 0, 1, 0, 0, 0, 1, 1, Z, 0, "vr_rise");
        step(1, 0, 1, 1, 0, 0, 1, 0, Z, 0, "vr_sync");
        step(1, 0, 1, 0, 1, 0, 1, 1, Z, 1, "v_abort");
        step(1, 0, 1, 0, 0, 0, 1, 1, Z, 1, "v_no_retrigger");
        step(1, 0, 1, 1, 0, 0, 1, 1, Z, 1, "v_no_retrigger");
        step(1, 0, 0, 0, 0, 0, 1, 1, Z, 1, "vr_release");

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
